poly_addsub_modq: RTL and testbench

Sequential coefficient-wise modular adder/subtractor for Kyber polynomials, sitting directly downstream of the operand multiplexer in the arithmetic datapath. It captures two selected polynomial operands of `KYBER_N` 16-bit coefficients each, computes `(a + b) mod q` or `(a - b) mod q` over several cycles using `LANES` parallel coefficient lanes, and holds the full result polynomial until the consumer accepts it. Operands are latched on acceptance, so the upstream selector may change as soon as the input handshake completes.

---
 rtl/poly_pkg.sv | 17 +
 rtl/params.vh | 8 +
 rtl/poly_addsub_modq_coeff.sv | 33 +++
 rtl/poly_addsub_modq.sv | 136 +++++++++++++
 tb/tb_poly_addsub_modq.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial add/sub block: ring constants,
// coefficient width and the controller state encoding.
`include "params.vh"

package poly_pkg;

    localparam int KYBER_N = `KYBER_N;
    localparam int KYBER_Q = `KYBER_Q;
    localparam int COEFF_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/params.vh
`ifndef POLY_PARAMS_VH
`define POLY_PARAMS_VH

// Kyber ring dimension and modulus shared across the arithmetic datapath.
`define KYBER_N 256
`define KYBER_Q 3329

`endif

// File: rtl/poly_addsub_modq_coeff.sv
// Single-coefficient modular add/sub lane. Purely combinational.
// Inputs are expected in [0, q-1]; out-of-range inputs still produce a
// deterministic value from the same formula, truncated to 16 bits.
module coeff_addsub_modq
    import poly_pkg::*;
(
    input  logic [COEFF_W-1:0] a,
    input  logic [COEFF_W-1:0] b,
    input  logic               sub,
    output logic [COEFF_W-1:0] r
);

    localparam logic [COEFF_W:0] Q_EXT = (COEFF_W + 1)'(KYBER_Q);

    logic [COEFF_W:0] sum;
    logic [COEFF_W:0] diff;
    logic [COEFF_W:0] sel;

    // One extra bit keeps the carry of a+b and the borrow of a-b visible.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        sel  = '0;
        if (sub) begin
            // Borrow (top bit set) means a negative difference: fold back by +q.
            sel = diff[COEFF_W] ? (diff + Q_EXT) : diff;
        end else begin
            sel = (sum >= Q_EXT) ? (sum - Q_EXT) : sum;
        end
        r = sel[COEFF_W-1:0];
    end

endmodule

// File: rtl/poly_addsub_modq.sv
// Sequential coefficient-wise (a +/- b) mod q over a full Kyber polynomial.
// Operands are captured on input acceptance, processed LANES coefficients
// per cycle, and the finished polynomial is held until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid is high only in HOLD,
// during which result is frozen. No input is accepted in the same cycle as
// the output handshake: in_ready rises the cycle after.
//
// LANES must divide KYBER_N and leave at least two chunks.
module poly_addsub_modq
    import poly_pkg::*;
#(
    parameter int LANES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       sub,
    input  logic [KYBER_N*COEFF_W-1:0] a_in,
    input  logic [KYBER_N*COEFF_W-1:0] b_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [KYBER_N*COEFF_W-1:0] result,
    output logic                       busy
);

    localparam int POLY_W  = KYBER_N * COEFF_W;
    localparam int CHUNK_W = LANES * COEFF_W;
    localparam int CHUNKS  = KYBER_N / LANES;
    localparam int CNT_W   = $clog2(CHUNKS);
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [POLY_W-1:0]  a_q;
    logic [POLY_W-1:0]  b_q;
    logic               sub_q;
    logic [31:0]        base;
    logic [CHUNK_W-1:0] a_chunk;
    logic [CHUNK_W-1:0] b_chunk;
    logic [CHUNK_W-1:0] r_chunk;
    logic               accept;

    assign accept  = in_valid && in_ready;
    // Bit offset of the chunk currently being processed.
    assign base    = {{(32 - CNT_W){1'b0}}, cnt} * 32'(CHUNK_W);
    assign a_chunk = a_q[base +: CHUNK_W];
    assign b_chunk = b_q[base +: CHUNK_W];

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs, decoded from the current state only.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST_CHUNK) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture on acceptance so the upstream selector is free to move on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
        end else if (accept) begin
            a_q   <= a_in;
            b_q   <= b_in;
            sub_q <= sub;
        end
    end

    // Chunk counter: cleared on acceptance, advanced once per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
        end
    end

    // LANES parallel modular lanes working on the current chunk.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        coeff_addsub_modq u_lane (
            .a   (a_chunk[g*COEFF_W +: COEFF_W]),
            .b   (b_chunk[g*COEFF_W +: COEFF_W]),
            .sub (sub_q),
            .r   (r_chunk[g*COEFF_W +: COEFF_W])
        );
    end

    // Decoded write of the finished chunk; other coefficients keep their value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
        end else if (state == RUN) begin
            result[base +: CHUNK_W] <= r_chunk;
        end
    end

endmodule

// File: tb/tb_poly_addsub_modq.sv
// Bench for poly_addsub_modq: table of uniform-operand vectors, hand-written
// sequences for borrow, backpressure and mid-run reset, then a randomized
// regression against a plain-arithmetic reference model.
module tb_poly_addsub_modq;
    import poly_pkg::*;

    localparam int LANES  = 16;
    localparam int N      = KYBER_N;
    localparam int CW     = COEFF_W;
    localparam int PW     = N * CW;
    localparam int Q      = KYBER_Q;
    localparam int CHUNKS = N / LANES;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          sub;
    logic [PW-1:0] a_in;
    logic [PW-1:0] b_in;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] result;
    logic          busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string name;
        int    a_val;
        int    b_val;
        bit    s;
        int    stall;
        int    exp_val;
    } vec_t;

    vec_t vecs[$];

    poly_addsub_modq #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_poly(input string name, input logic [PW-1:0] got,
                              input logic [PW-1:0] exp);
        tests++;
        if (got !== exp) begin
            int first;
            first = -1;
            for (int i = N - 1; i >= 0; i--) begin
                if (got[i*CW +: CW] !== exp[i*CW +: CW]) first = i;
            end
            fails++;
            $display("FAIL %s: coeff %0d got %0d expected %0d", name, first,
                     got[first*CW +: CW], exp[first*CW +: CW]);
        end
    endtask

    function automatic logic [PW-1:0] fill_const(input int v);
        logic [PW-1:0] p;
        for (int i = 0; i < N; i++) p[i*CW +: CW] = CW'(v);
        return p;
    endfunction

    // Reference: plain integer modular arithmetic per coefficient.
    function automatic logic [PW-1:0] ref_model(input logic [PW-1:0] a,
                                                input logic [PW-1:0] b,
                                                input bit s);
        logic [PW-1:0] p;
        for (int i = 0; i < N; i++) begin
            int x;
            int y;
            int r;
            x = int'(a[i*CW +: CW]);
            y = int'(b[i*CW +: CW]);
            if (s) r = (((x - y) % Q) + Q) % Q;
            else   r = (x + y) % Q;
            p[i*CW +: CW] = CW'(r);
        end
        return p;
    endfunction

    // Driver: one full transaction with an optional stall in HOLD.
    task automatic run_op(input string name, input logic [PW-1:0] a,
                          input logic [PW-1:0] b, input bit s, input int stall,
                          output logic [PW-1:0] got);
        int guard;
        int lat;
        bit stable;
        bit rdy_low;
        logic [PW-1:0] held;
        got = '0;
        a_in = a;
        b_in = b;
        sub = s;
        in_valid = 1'b1;
        out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            check_int({name, "_in_ready_timeout"}, 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Accepted at that edge: scramble the inputs to prove they were latched.
        in_valid = 1'b0;
        a_in = ~a;
        b_in = ~b;
        sub = ~s;
        lat = 0;
        while (!out_valid && lat < 100) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check_int({name, "_latency"}, lat, CHUNKS);
        if (!out_valid) return;
        held = result;
        stable = 1'b1;
        rdy_low = 1'b1;
        for (int c = 0; c < stall; c++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            if (result !== held || !out_valid) stable = 1'b0;
            if (in_ready) rdy_low = 1'b0;
        end
        in_valid = 1'b0;
        if (stall > 0) begin
            check_int({name, "_hold_stable"}, int'(stable), 1);
            check_int({name, "_hold_in_ready_low"}, int'(rdy_low), 1);
        end
        got = result;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_int({name, "_in_ready_after"}, int'(in_ready), 1);
        check_int({name, "_out_valid_after"}, int'(out_valid), 0);
    endtask

    initial begin
        logic [PW-1:0] got;
        logic [PW-1:0] ra;
        logic [PW-1:0] rb;
        logic [PW-1:0] exp_p;
        bit rs;
        int st;

        // Reset
        rst_n = 1'b0;
        in_valid = 1'b0;
        sub = 1'b0;
        out_ready = 1'b0;
        a_in = '0;
        b_in = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check_int("reset_in_ready", int'(in_ready), 1);
        check_int("reset_out_valid", int'(out_valid), 0);
        check_int("reset_busy", int'(busy), 0);
        check_poly("reset_result", result, '0);

        // Uniform-operand vectors with hand-derived expectations.
        vecs.push_back('{"add_wrap",     3000,  500, 1'b0, 20,  171});
        vecs.push_back('{"add_max_1",    3328,    1, 1'b0,  0,    0});
        vecs.push_back('{"sub_zero",        0,    0, 1'b1,  0,    0});
        vecs.push_back('{"sub_0_max",       0, 3328, 1'b1,  2,    1});
        vecs.push_back('{"add_max_max",  3328, 3328, 1'b0,  0, 3327});
        vecs.push_back('{"add_nowrap",    100,  200, 1'b0,  1,  300});
        vecs.push_back('{"sub_nowrap",   3328, 3328, 1'b1,  0,    0});
        for (int v = 0; v < vecs.size(); v++) begin
            run_op(vecs[v].name, fill_const(vecs[v].a_val),
                   fill_const(vecs[v].b_val), vecs[v].s, vecs[v].stall, got);
            check_poly(vecs[v].name, got, fill_const(vecs[v].exp_val));
        end

        // Sub with borrow: a_i = i, b_i = 10.
        for (int i = 0; i < N; i++) begin
            ra[i*CW +: CW] = CW'(i);
            exp_p[i*CW +: CW] = (i < 10) ? CW'(3319 + i) : CW'(i - 10);
        end
        run_op("sub_borrow", ra, fill_const(10), 1'b1, 3, got);
        check_poly("sub_borrow", got, exp_p);

        // Reset in the middle of RUN.
        a_in = fill_const(5);
        b_in = fill_const(7);
        sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_int("midrun_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_int("midrun_rst_in_ready", int'(in_ready), 1);
        check_int("midrun_rst_out_valid", int'(out_valid), 0);
        check_int("midrun_rst_busy", int'(busy), 0);
        check_poly("midrun_rst_result", result, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_int("post_rst_in_ready", int'(in_ready), 1);
        run_op("post_rst_op", fill_const(5), fill_const(7), 1'b0, 0, got);
        check_poly("post_rst_op", got, fill_const(12));

        // Randomized regression against the reference model.
        for (int t = 0; t < 1000; t++) begin
            for (int i = 0; i < N; i++) begin
                ra[i*CW +: CW] = CW'($urandom_range(0, Q - 1));
                rb[i*CW +: CW] = CW'($urandom_range(0, Q - 1));
            end
            rs = 1'($urandom_range(0, 1));
            st = $urandom_range(0, 3);
            run_op("rand", ra, rb, rs, st, got);
            check_poly("rand", got, ref_model(ra, rb, rs));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
